// File: rtl/ppa_pkg.sv
// Shared types and the prefix combine operator for the pipelined prefix adder.
package ppa_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_pair_t;

    // (G,P)hi o (G,P)lo
    function automatic gp_pair_t gp_combine(input gp_pair_t hi, input gp_pair_t lo);
        gp_pair_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/gp_prefix_level.sv
// One Kogge-Stone level: each position combines with the position DIST below it.
module gp_prefix_level
    import ppa_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIST  = 1
) (
    input  gp_pair_t [WIDTH-1:0] gp_in,
    output gp_pair_t [WIDTH-1:0] gp_out
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i >= DIST) begin : g_comb
            assign gp_out[i] = gp_combine(gp_in[i], gp_in[i-DIST]);
        end else begin : g_pass
            assign gp_out[i] = gp_in[i];
        end
    end

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder with valid/ready handshake and global stall.
// Optional signed-overflow output enabled by defining PPA_OVERFLOW_EN.
module pipelined_prefix_adder
    import ppa_pkg::*;
#(
    parameter int unsigned WIDTH            = 32,
    parameter int unsigned LEVELS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PPA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned L    = $clog2(WIDTH);
    localparam int unsigned NSTG = (L + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

    typedef gp_pair_t [WIDTH-1:0] gp_vec_t;

    logic                         advance;
    logic    [NSTG:0]             stg_vld;
    logic    [NSTG:0]             stg_cin;
    logic    [NSTG:0][WIDTH-1:0]  stg_p;
    gp_vec_t [NSTG:0]             stg_gp;
    gp_vec_t [NSTG:0]             nxt_gp;
    gp_vec_t                      fin;
    logic    [WIDTH-1:0]          fin_g;
    logic    [WIDTH-1:0]          fin_p;
    logic                         unused_fin_p;

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = stg_vld[NSTG];

    // Bitwise generate/propagate; cin is absorbed into the bit-0 generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_gen
        if (i == 0) begin : g_lsb
            assign nxt_gp[0][i].g = (a[i] & b[i]) | ((a[i] ^ b[i]) & cin);
        end else begin : g_bit
            assign nxt_gp[0][i].g = a[i] & b[i];
        end
        assign nxt_gp[0][i].p = a[i] ^ b[i];
    end

    // Prefix levels; a level starting a new stage reads that stage's register
    for (genvar j = 0; j < L; j++) begin : g_lvl
        gp_vec_t lvl_in;
        gp_vec_t lvl_out;
        if (j % LEVELS_PER_STAGE == 0) begin : g_from_reg
            assign lvl_in = stg_gp[j / LEVELS_PER_STAGE];
        end else begin : g_from_lvl
            assign lvl_in = g_lvl[j-1].lvl_out;
        end
        gp_prefix_level #(
            .WIDTH (WIDTH),
            .DIST  (2 ** j)
        ) u_level (
            .gp_in  (lvl_in),
            .gp_out (lvl_out)
        );
    end

    for (genvar s = 1; s <= NSTG; s++) begin : g_stage
        localparam int unsigned LAST =
            ((s * LEVELS_PER_STAGE < L) ? s * LEVELS_PER_STAGE : L) - 1;
        assign nxt_gp[s] = g_lvl[LAST].lvl_out;
    end

    // Pipeline registers; the whole pipe holds while the output is blocked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_vld <= '0;
            stg_cin <= '0;
            stg_p   <= '0;
            stg_gp  <= '0;
        end else if (advance) begin
            stg_vld <= {stg_vld[NSTG-1:0], in_valid};
            stg_cin <= {stg_cin[NSTG-1:0], cin};
            stg_p   <= {stg_p[NSTG-1:0], a ^ b};
            stg_gp  <= nxt_gp;
        end
    end

    assign fin = stg_gp[NSTG];

    for (genvar i = 0; i < WIDTH; i++) begin : g_fin
        assign fin_g[i] = fin[i].g;
        assign fin_p[i] = fin[i].p;
    end

    assign unused_fin_p = ^fin_p;

    assign sum  = stg_p[NSTG] ^ {fin_g[WIDTH-2:0], stg_cin[NSTG]};
    assign cout = fin_g[WIDTH-1];

`ifdef PPA_OVERFLOW_EN
    assign ovf = fin_g[WIDTH-2] ^ fin_g[WIDTH-1];
`endif

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Self-checking bench for pipelined_prefix_adder (WIDTH=8, LEVELS_PER_STAGE=1, latency 4).
module tb_pipelined_prefix_adder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
`ifdef PPA_OVERFLOW_EN
    logic       ovf;
`endif

    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;
    int n_out = 0;
    bit done  = 0;

    // Expected {ovf, cout, sum} per accepted operand set, oldest first
    logic [9:0] exp_q [$];

    // Hand-computed directed vectors
    logic [7:0] ta [8] = '{8'h12, 8'hF0, 8'hAA, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'h3C};
    logic [7:0] tb [8] = '{8'h34, 8'h0F, 8'h55, 8'h80, 8'h01, 8'h00, 8'hFF, 8'hC3};
    logic       tc [8] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};
    logic [9:0] te [8] = '{10'h046, 10'h100, 10'h0FF, 10'h300, 10'h280, 10'h001, 10'h1FF, 10'h100};

    pipelined_prefix_adder #(
        .WIDTH            (8),
        .LEVELS_PER_STAGE (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef PPA_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] s;
        logic       v;
        s = {1'b0, x} + {1'b0, y} + 9'(c);
        v = (x[7] == y[7]) && (s[7] != x[7]);
        return {v, s};
    endfunction

    // Present operands until accepted; the transfer completes at the next rising edge
    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic c, input logic [9:0] e);
        @(posedge clk);
        #1;
        a = x; b = y; cin = c; in_valid = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (in_ready && rst_n) begin
                exp_q.push_back(e);
                n_acc++;
                return;
            end
        end
        chk("send_timeout", 16'd0, 16'd1);
    endtask

    task automatic idle();
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_ov(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                return;
            end
        end
        chk("wait_out_valid", 16'd0, 16'd1);
    endtask

    task automatic drain(input string tag);
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
        chk(tag, 16'(exp_q.size()), 16'd0);
    endtask

    // Output scoreboard
    always @(negedge clk) begin
        logic [9:0] e;
        if (!rst_n) begin
            exp_q.delete();
        end else if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 16'd1, 16'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sum", 16'(sum), 16'(e[7:0]));
                chk("cout", 16'(cout), 16'(e[8]));
`ifdef PPA_OVERFLOW_EN
                chk("ovf", 16'(ovf), 16'(e[9]));
`endif
                n_out++;
            end
        end
    end

    initial begin
        bit ok;
        int run;
        int seen;
        logic [7:0] held;
        logic [7:0] x, y;
        logic       c;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        #2;
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_sum", 16'(sum), 16'd0);
        chk("rst_cout", 16'(cout), 16'd0);
        chk("rst_in_ready", 16'(in_ready), 16'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", 16'(in_ready), 16'd1);

        // Latency: result visible exactly four cycles after presentation
        send(8'hFF, 8'h01, 1'b0, 10'h100);
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lat_early_valid", 16'(out_valid), 16'd0);
            @(posedge clk);
        end
        @(negedge clk);
        chk("lat_valid", 16'(out_valid), 16'd1);
        chk("lat_sum", 16'(sum), 16'h00);
        chk("lat_cout", 16'(cout), 16'd1);
        drain("drain_latency");

        for (int j = 0; j < 8; j++) send(ta[j], tb[j], tc[j], te[j]);
        idle();
        drain("drain_directed");

        // Back-to-back: 16 results on consecutive cycles
        fork
            begin
                for (int j = 0; j < 16; j++) begin
                    x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
                    send(x, y, c, model(x, y, c));
                end
                idle();
            end
            begin
                wait_ov(ok);
                run = 0;
                while (ok && out_valid && run < 40) begin
                    run++;
                    @(negedge clk);
                end
                chk("b2b_run", 16'(run), 16'd16);
            end
        join
        drain("drain_b2b");

        // Output stall with six operands offered
        out_ready = 1'b0;
        fork
            begin
                for (int j = 0; j < 6; j++) send(ta[j], tb[j], tc[j], te[j]);
                idle();
            end
            begin
                wait_ov(ok);
                held = sum;
                chk("stall_first_sum", 16'(sum), 16'h46);
                chk("stall_in_ready", 16'(in_ready), 16'd0);
                repeat (2) begin
                    @(posedge clk);
                    @(negedge clk);
                    chk("stall_hold_valid", 16'(out_valid), 16'd1);
                    chk("stall_hold_sum", 16'(sum), 16'(held));
                    chk("stall_hold_ready", 16'(in_ready), 16'd0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("drain_stall");
        chk("stall_count", 16'(n_out), 16'(n_acc));

        // Reset with operands in flight
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) send(ta[j], tb[j], tc[j], te[j]);
        idle();
        wait_ov(ok);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 16'(out_valid), 16'd0);
        chk("midrst_sum", 16'(sum), 16'd0);
        chk("midrst_in_ready", 16'(in_ready), 16'd1);
        n_acc = 0;
        n_out = 0;
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("post_rst_stale", 16'(seen), 16'd0);
        send(8'h7F, 8'h01, 1'b0, 10'h280);
        idle();
        wait_ov(ok);
        chk("post_rst_first", 16'(sum), 16'h80);
        drain("drain_post_rst");

        // Random handshake traffic
        done = 1'b0;
        fork
            begin
                for (int n = 0; n < 10000; n++) begin
                    if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) idle();
                    x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
                    send(x, y, c, model(x, y, c));
                end
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain("drain_random");
        chk("total_count", 16'(n_out), 16'(n_acc));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipelined_prefix_adder.md
PIPELINED_PREFIX_ADDER -- requirements
Module: pipelined_prefix_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width (power of two, 4..64).
REQ-002 SHALL have parameter LEVELS_PER_STAGE, default 2, number of prefix levels between pipeline registers (1..clog2(WIDTH)).
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, operands present.
REQ-006 SHALL have port in_ready, output, 1, operands accepted this cycle.
REQ-007 SHALL have ports a and b, input, WIDTH each, addends.
REQ-008 SHALL have port cin, input, 1, carry-in.
REQ-009 SHALL have port out_valid, output, 1, result present.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port sum, output, WIDTH, a+b+cin modulo 2^WIDTH.
REQ-012 SHALL have port cout, output, 1, carry out of bit WIDTH-1.

Function
REQ-013 SHALL compute bitwise p=a^b, g=a&b, with cin folded in as bit -1 generate.
REQ-014 SHALL compute group (G,P) for every prefix [0..i] with a Kogge-Stone network of L=clog2(WIDTH) levels, combining (G,P)hi o (G,P)lo = (Ghi | Phi&Glo, Phi&Plo).
REQ-015 SHALL register after p/g generation and after every LEVELS_PER_STAGE prefix levels; latency LAT = 1 + ceil(L/LEVELS_PER_STAGE) cycles from accepted input to out_valid.
REQ-016 SHALL form sum[i] = p[i] ^ G[i-1] (G[-1]=cin) and cout = G[WIDTH-1] combinationally from the last register.
REQ-017 SHALL accept a transfer when in_valid && in_ready; SHALL produce a result transfer when out_valid && out_ready.
REQ-018 SHALL drive in_ready = !out_valid || out_ready (global stall: all stages hold when output blocked).
REQ-019 SHALL carry a valid bit per stage; bubbles advance when not stalled; throughput one result per cycle when out_ready held high.
REQ-020 SHALL hold sum, cout and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL preserve input order; no result dropped or duplicated under any in_valid/out_ready pattern.
REQ-022 SHALL, on simultaneous accept and output transfer in a cycle, advance every stage by one.

Reset
REQ-023 SHALL, on rst_n low, asynchronously clear every stage valid bit; out_valid=0, sum=0, cout=0.
REQ-024 SHALL discard in-flight operands on reset mid-operation; first output after release comes from the first post-reset accept.
REQ-025 SHALL drive in_ready=1 during and immediately after reset.

Configuration
REQ-026 SHALL, with PPA_OVERFLOW_EN defined, add output ovf (1 bit) = signed overflow (cout of bit WIDTH-2 XOR cout), pipelined with sum and reset to 0.
REQ-027 SHALL, without PPA_OVERFLOW_EN, have no ovf port and no related logic.

Structure
REQ-028 SHALL place gp_pair_t typedef (g,p bits) and the combine function in shared package ppa_pkg.
REQ-029 SHALL instantiate sub-module gp_prefix_level (one Kogge-Stone level, parameters WIDTH and DIST) L times.

Verification (WIDTH=8, LEVELS_PER_STAGE=1, LAT=4)
REQ-030 Reset then a=8'hFF, b=8'h01, cin=0, out_ready=1 -> out_valid high exactly 4 cycles later, sum=8'h00, cout=1.
REQ-031 Back-to-back 16 random pairs with out_ready=1 -> 16 consecutive results in order, one per cycle, all equal a+b+cin.
REQ-032 out_ready=0 for 6 cycles with 6 inputs offered -> in_ready drops once out_valid=1; sum held; after out_ready=1, all accepted results emerge in order, none lost.
REQ-033 rst_n pulsed low with 3 operands in flight -> out_valid=0 immediately; no stale result after release.
REQ-034 a=8'h7F, b=8'h01, cin=0 with PPA_OVERFLOW_EN -> sum=8'h80, cout=0, ovf=1; a=8'h80, b=8'h80 -> sum=8'h00, cout=1, ovf=1.
REQ-035 Random in_valid/out_ready toggling, 10000 transfers -> scoreboard match, count of outputs equals count of accepts.
